// File: rtl/en_reg_fifo.sv
// en_reg_fifo: in-order FIFO built from per-word enabled registers, registered read port.
// Define EN_REG_FIFO_ERR_FLAGS_EN to add sticky ovf/udf error outputs.
module en_reg_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
`ifdef EN_REG_FIFO_ERR_FLAGS_EN
  ,
  output logic              ovf,
  output logic              udf
`endif
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  wen;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              wr_acc, rd_acc;
  always_comb begin
    wr_acc    = wr_en && !full;
    rd_acc    = rd_en && !empty;
    wr_ptr_d  = wr_ptr_q + ADDR_W'(wr_acc);
    rd_ptr_d  = rd_ptr_q + ADDR_W'(rd_acc);
    count_d   = count_q + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(rd_acc);
    rd_data_d = rd_acc ? mem_q[rd_ptr_q] : rd_data_q;
    wen       = '0;
    wen[wr_ptr_q] = wr_acc;
  end
  // storage words carry no reset; the empty guard keeps unwritten words unobservable
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++)
      if (wen[i]) mem_q[i] <= wr_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end
  assign rd_data = rd_data_q;
  assign count   = count_q;
  assign full    = count_q == (ADDR_W+1)'(DEPTH);
  assign empty   = count_q == '0;
`ifdef EN_REG_FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d, udf_q, udf_d;
  always_comb begin
    ovf_d = ovf_q || (wr_en && full);
    udf_d = udf_q || (rd_en && empty);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end
  assign ovf = ovf_q;
  assign udf = udf_q;
`endif
endmodule
